// File: rtl/mistral_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mistral_mul_pkg
// Description : Shared widths, helper function and stage-1 record for the
//               shared 27x27 multiplier slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mistral_mul_pkg;

    localparam int MUL_W  = 27;
    localparam int PROD_W = 54;

    // Widest requester index ever carried (up to 8 requesters)
    localparam int c_ID_MAX_W = 3;

    // Index width for n requesters, never narrower than one bit
    function automatic int id_width(input int n);
        if ($clog2(n) < 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // First pipeline stage: operands plus issuing requester
    typedef struct packed {
        logic                  valid;
        logic [c_ID_MAX_W-1:0] id;
        logic [MUL_W-1:0]      a;
        logic [MUL_W-1:0]      b;
    } stage1_t;

endpackage
`default_nettype wire

// File: rtl/mistral_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mistral_rr_arbiter
// Description : Round-robin arbiter. Grant goes to the first requester found
//               scanning from the pointer upward with wrap; the pointer moves
//               past the winner only when a transfer actually happens.
// Revision    : 1.0 - initial release
// ============================================================================
module mistral_rr_arbiter
    import mistral_mul_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           i_req,
    input  logic                   i_advance_en,
    output logic [N-1:0]           o_grant,
    output logic [id_width(N)-1:0] o_gidx,
    output logic                   o_any,
    output logic [id_width(N)-1:0] o_ptr
);

    localparam int c_PTR_W = id_width(N);

    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_gidx;
    logic               w_found;

    // Priority scan: first pass covers ptr..N-1, second pass wraps to 0..ptr-1
    always_comb begin
        w_gidx  = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[i] && (c_PTR_W'(i) >= r_ptr)) begin
                w_gidx  = c_PTR_W'(i);
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[i]) begin
                w_gidx  = c_PTR_W'(i);
                w_found = 1'b1;
            end
        end
    end

    // One-hot expansion of the winning index
    always_comb begin
        o_grant = '0;
        for (int i = 0; i < N; i++) begin
            o_grant[i] = w_found && (w_gidx == c_PTR_W'(i));
        end
    end

    // Pointer moves to the slot after the winner on each transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance_en && w_found) begin
            r_ptr <= (w_gidx == c_PTR_W'(N - 1)) ? '0 : w_gidx + c_PTR_W'(1);
        end
    end

    assign o_gidx = w_gidx;
    assign o_any  = w_found;
    assign o_ptr  = r_ptr;

endmodule
`default_nettype wire

// File: rtl/mistral_mul_share.sv
`default_nettype none
// ============================================================================
// Module      : mistral_mul_share
// Description : One 27x27 hard multiplier shared by NREQ valid/ready
//               requesters through a round-robin arbiter and a LATENCY-deep
//               lock-step pipeline with a single tagged response port.
// Revision    : 1.0 - initial release
// ============================================================================
module mistral_mul_share
    import mistral_mul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = 2,
    parameter int SIGNED  = 1
) (
    input  logic                      CLK,
    input  logic                      SCLR,
    input  logic [NREQ-1:0]           REQ_VALID,
    output logic [NREQ-1:0]           REQ_READY,
    input  logic [NREQ*MUL_W-1:0]     REQ_A,
    input  logic [NREQ*MUL_W-1:0]     REQ_B,
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [id_width(NREQ)-1:0] RSP_ID,
    output logic [PROD_W-1:0]         RSP_Y,
    output logic                      BUSY
);

    localparam int c_ID_W = id_width(NREQ);

    stage1_t             r_s1;
    logic                w_out_valid;
    logic                w_adv;
    logic                w_advance_en;
    logic                w_tail_busy;
    logic [NREQ-1:0]     w_grant;
    logic [c_ID_W-1:0]   w_gidx;
    logic [c_ID_W-1:0]   w_rr_ptr;
    logic                w_any;
    logic [MUL_W-1:0]    w_sel_a;
    logic [MUL_W-1:0]    w_sel_b;
    logic [PROD_W-1:0]   w_prod;
    logic                w_unused;

    // Whole pipe shifts together unless the output stage is held by backpressure
    assign w_adv        = !w_out_valid || RSP_READY;
    assign w_advance_en = w_adv && !SCLR;

    mistral_rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk          (CLK),
        .rst          (SCLR),
        .i_req        (REQ_VALID),
        .i_advance_en (w_advance_en),
        .o_grant      (w_grant),
        .o_gidx       (w_gidx),
        .o_any        (w_any),
        .o_ptr        (w_rr_ptr)
    );

    assign REQ_READY = w_grant & {NREQ{w_advance_en}};

    // Operand select from the granted requester
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = REQ_A[MUL_W*i +: MUL_W];
                w_sel_b = REQ_B[MUL_W*i +: MUL_W];
            end
        end
    end

    // Stage 1 captures operands and requester index on a transfer, a bubble otherwise
    always_ff @(posedge CLK) begin
        if (SCLR) begin
            r_s1.valid <= 1'b0;
        end else if (w_adv) begin
            r_s1.valid <= w_any;
            if (w_any) begin
                r_s1.id <= c_ID_MAX_W'(w_gidx);
                r_s1.a  <= w_sel_a;
                r_s1.b  <= w_sel_b;
            end
        end
    end

    // Combinational 27x27 product out of stage 1; maps onto the hard multiplier
    if (SIGNED != 0) begin : g_signed
        logic signed [PROD_W-1:0] w_sa;
        logic signed [PROD_W-1:0] w_sb;
        assign w_sa   = PROD_W'($signed(r_s1.a));
        assign w_sb   = PROD_W'($signed(r_s1.b));
        assign w_prod = w_sa * w_sb;
    end else begin : g_unsigned
        assign w_prod = PROD_W'(r_s1.a) * PROD_W'(r_s1.b);
    end

    if (LATENCY == 1) begin : g_lat1
        assign w_out_valid = r_s1.valid;
        assign RSP_ID      = r_s1.id[c_ID_W-1:0];
        assign RSP_Y       = w_prod;
        assign w_tail_busy = 1'b0;
    end else begin : g_latn
        logic [LATENCY:2]  r_v;
        logic [c_ID_W-1:0] r_id [2:LATENCY];
        logic [PROD_W-1:0] r_y  [2:LATENCY];

        // Product stages shift in lock-step with stage 1, bubbles included
        always_ff @(posedge CLK) begin
            if (SCLR) begin
                r_v <= '0;
            end else if (w_adv) begin
                r_v[2]  <= r_s1.valid;
                r_id[2] <= r_s1.id[c_ID_W-1:0];
                r_y[2]  <= w_prod;
                for (int s = 3; s <= LATENCY; s++) begin
                    r_v[s]  <= r_v[s-1];
                    r_id[s] <= r_id[s-1];
                    r_y[s]  <= r_y[s-1];
                end
            end
        end

        assign w_out_valid = r_v[LATENCY];
        assign RSP_ID      = r_id[LATENCY];
        assign RSP_Y       = r_y[LATENCY];
        assign w_tail_busy = |r_v;
    end

    assign RSP_VALID = w_out_valid;
    assign BUSY      = r_s1.valid || w_tail_busy;

    // Upper index bits and the pointer are not needed for every NREQ
    assign w_unused = ^{r_s1.id, w_rr_ptr};

endmodule
`default_nettype wire

// File: tb/tb_mistral_mul_share.sv
`default_nettype none
// ============================================================================
// Module      : tb_mistral_mul_share
// Description : Self-checking bench for mistral_mul_share (NREQ=4, LATENCY=2)
//               against a spec-level model of arbitration and pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mistral_mul_share;

    localparam int N = 4;
    localparam int L = 2;

    logic            clk = 1'b0;
    logic            sclr;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*27-1:0] req_a;
    logic [N*27-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [53:0]     rsp_y;
    logic            busy;

    logic [N-1:0]    u_req_ready;
    logic            u_rsp_valid;
    logic [1:0]      u_rsp_id;
    logic [53:0]     u_rsp_y;
    logic            u_busy;

    always #5 clk = ~clk;

    mistral_mul_share #(.NREQ(N), .LATENCY(L), .SIGNED(1)) dut (
        .CLK(clk), .SCLR(sclr), .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_A(req_a), .REQ_B(req_b), .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
        .RSP_ID(rsp_id), .RSP_Y(rsp_y), .BUSY(busy)
    );

    mistral_mul_share #(.NREQ(N), .LATENCY(L), .SIGNED(0)) dut_u (
        .CLK(clk), .SCLR(sclr), .REQ_VALID(req_valid), .REQ_READY(u_req_ready),
        .REQ_A(req_a), .REQ_B(req_b), .RSP_VALID(u_rsp_valid), .RSP_READY(rsp_ready),
        .RSP_ID(u_rsp_id), .RSP_Y(u_rsp_y), .BUSY(u_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: round-robin pointer and L lock-step slots
    int          m_ptr = 0;
    bit          m_v [1:L];
    int          m_id[1:L];
    logic [53:0] m_y [1:L];
    int          m_g;
    bit          m_adv;
    int          last_acc;

    logic [N-1:0] exp_ready;
    bit           exp_valid;
    bit           exp_busy;
    int           exp_id;
    logic [53:0]  exp_y;

    function automatic logic [53:0] ref_mul(input logic [26:0] a, input logic [26:0] b, input bit sgn);
        longint sa, sb, p;
        sa = a;
        sb = b;
        if (sgn && a[26]) sa = sa - (longint'(1) << 27);
        if (sgn && b[26]) sb = sb - (longint'(1) << 27);
        p = sa * sb;
        return p[53:0];
    endfunction

    // Expected outputs for the current cycle from model state and current inputs
    task automatic model_eval();
        m_adv = !m_v[L] || rsp_ready;
        m_g   = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (m_g < 0 && req_valid[i]) m_g = i;
        end
        exp_ready = '0;
        if (!sclr && m_adv && m_g >= 0) exp_ready[m_g] = 1'b1;
        exp_valid = m_v[L];
        exp_id    = m_id[L];
        exp_y     = m_y[L];
        exp_busy  = 1'b0;
        for (int s = 1; s <= L; s++) exp_busy = exp_busy | m_v[s];
    endtask

    // Apply the effect of the coming clock edge to the model
    task automatic model_commit();
        last_acc = -1;
        if (sclr) begin
            for (int s = 1; s <= L; s++) m_v[s] = 1'b0;
            m_ptr = 0;
        end else if (m_adv) begin
            for (int s = L; s >= 2; s--) begin
                m_v[s]  = m_v[s-1];
                m_id[s] = m_id[s-1];
                m_y[s]  = m_y[s-1];
            end
            m_v[1] = (m_g >= 0);
            if (m_g >= 0) begin
                m_id[1]  = m_g;
                m_y[1]   = ref_mul(req_a[27*m_g +: 27], req_b[27*m_g +: 27], 1'b1);
                m_ptr    = (m_g + 1) % N;
                last_acc = m_g;
            end
        end
    endtask

    task automatic new_operands(input int i);
        req_a[27*i +: 27] = 27'($urandom);
        req_b[27*i +: 27] = 27'($urandom);
    endtask

    task automatic test_reset();
        sclr      = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            model_eval();
            n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL reset req_ready got %b want %b", req_ready, exp_ready); end
            n_vec++; if (rsp_valid !== exp_valid) begin n_err++; $display("FAIL reset rsp_valid got %b want %b", rsp_valid, exp_valid); end
            n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL reset busy got %b want %b", busy, exp_busy); end
            model_commit();
            @(posedge clk); #1;
        end
        sclr      = 1'b0;
        req_valid = '0;
    endtask

    // Single request; also used for the signed/unsigned boundary operands
    task automatic test_single(input string name, input logic [26:0] a, input logic [26:0] b,
                               input logic [53:0] want_s, input logic [53:0] want_u);
        rsp_ready  = 1'b1;
        req_a[26:0] = a;
        req_b[26:0] = b;
        req_valid  = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            model_eval();
            n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL %s req_ready got %b want %b", name, req_ready, exp_ready); end
            n_vec++; if (rsp_valid !== exp_valid) begin n_err++; $display("FAIL %s rsp_valid got %b want %b", name, rsp_valid, exp_valid); end
            if (exp_valid) begin
                n_vec++; if ({rsp_id, rsp_y} !== {2'(exp_id), exp_y}) begin n_err++; $display("FAIL %s rsp got id %0d y %h want id %0d y %h", name, rsp_id, rsp_y, exp_id, exp_y); end
            end
            n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL %s busy got %b want %b", name, busy, exp_busy); end
            if (c == 2) begin
                n_vec++; if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'd0, want_s}) begin n_err++; $display("FAIL %s signed result got v%b id %0d y %h want y %h", name, rsp_valid, rsp_id, rsp_y, want_s); end
                n_vec++; if ({u_rsp_valid, u_rsp_y} !== {1'b1, want_u}) begin n_err++; $display("FAIL %s unsigned result got v%b y %h want y %h", name, u_rsp_valid, u_rsp_y, want_u); end
            end
            if (c == 3) begin
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_drop got %b want 0", name, busy); end
            end
            model_commit();
            @(posedge clk); #1;
            if (last_acc == 0) req_valid = '0;
        end
    endtask

    // All requesters valid; rsp_ready from a pattern (or random) to exercise freezes
    task automatic test_stream(input string name, input int cycles, input int stall_from, input bit rnd_ready);
        for (int i = 0; i < N; i++) new_operands(i);
        req_valid = '1;
        for (int c = 0; c < cycles; c++) begin
            if (rnd_ready) rsp_ready = ($urandom_range(0, 9) < 6);
            else           rsp_ready = !(c >= stall_from && c < stall_from + 3);
            @(negedge clk);
            model_eval();
            n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL %s req_ready c%0d got %b want %b", name, c, req_ready, exp_ready); end
            n_vec++; if (rsp_valid !== exp_valid) begin n_err++; $display("FAIL %s rsp_valid c%0d got %b want %b", name, c, rsp_valid, exp_valid); end
            if (exp_valid) begin
                n_vec++; if ({rsp_id, rsp_y} !== {2'(exp_id), exp_y}) begin n_err++; $display("FAIL %s rsp c%0d got id %0d y %h want id %0d y %h", name, c, rsp_id, rsp_y, exp_id, exp_y); end
            end
            n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL %s busy c%0d got %b want %b", name, c, busy, exp_busy); end
            model_commit();
            @(posedge clk); #1;
            if (last_acc >= 0) new_operands(last_acc);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
    endtask

    // Random valids and random backpressure; a requester may drop out unserved
    task automatic test_random(input int cycles);
        req_valid = '0;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_acc == i || $urandom_range(0, 7) == 0) begin
                    req_valid[i] = $urandom_range(0, 1);
                    new_operands(i);
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            model_eval();
            n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL random req_ready c%0d got %b want %b", c, req_ready, exp_ready); end
            n_vec++; if (rsp_valid !== exp_valid) begin n_err++; $display("FAIL random rsp_valid c%0d got %b want %b", c, rsp_valid, exp_valid); end
            if (exp_valid) begin
                n_vec++; if ({rsp_id, rsp_y} !== {2'(exp_id), exp_y}) begin n_err++; $display("FAIL random rsp c%0d got id %0d y %h want id %0d y %h", c, rsp_id, rsp_y, exp_id, exp_y); end
            end
            n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL random busy c%0d got %b want %b", c, busy, exp_busy); end
            model_commit();
            @(posedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
    endtask

    // Grant to 2, then only 1 and 3 valid: 3 must win before 1
    task automatic test_rr_order();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) new_operands(i);
        req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            model_eval();
            n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rr req_ready c%0d got %b want %b", c, req_ready, exp_ready); end
            n_vec++; if (rsp_valid !== exp_valid) begin n_err++; $display("FAIL rr rsp_valid c%0d got %b want %b", c, rsp_valid, exp_valid); end
            if (exp_valid) begin
                n_vec++; if ({rsp_id, rsp_y} !== {2'(exp_id), exp_y}) begin n_err++; $display("FAIL rr rsp c%0d got id %0d y %h want id %0d y %h", c, rsp_id, rsp_y, exp_id, exp_y); end
            end
            if (c == 1) begin
                n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rr first_after_2 got %b want 1000", req_ready); end
            end
            if (c == 2) begin
                n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rr second_after_2 got %b want 0010", req_ready); end
            end
            model_commit();
            @(posedge clk); #1;
            if (c == 0) req_valid = 4'b1010;
            if (last_acc >= 0 && c > 0) req_valid[last_acc] = 1'b0;
        end
        req_valid = '0;
    endtask

    // Two products in flight, one-cycle reset, then contention must go to 0
    task automatic test_flush();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) new_operands(i);
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: begin req_valid = 4'b0010; sclr = 1'b0; end
                1: begin req_valid = 4'b0100; end
                2: begin req_valid = 4'b0000; sclr = 1'b1; rsp_ready = 1'b0; end
                3: begin req_valid = 4'b1111; sclr = 1'b0; rsp_ready = 1'b1; end
                default: req_valid = 4'b0000;
            endcase
            @(negedge clk);
            model_eval();
            n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL flush req_ready c%0d got %b want %b", c, req_ready, exp_ready); end
            n_vec++; if (rsp_valid !== exp_valid) begin n_err++; $display("FAIL flush rsp_valid c%0d got %b want %b", c, rsp_valid, exp_valid); end
            if (exp_valid) begin
                n_vec++; if ({rsp_id, rsp_y} !== {2'(exp_id), exp_y}) begin n_err++; $display("FAIL flush rsp c%0d got id %0d y %h want id %0d y %h", c, rsp_id, rsp_y, exp_id, exp_y); end
            end
            n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL flush busy c%0d got %b want %b", c, busy, exp_busy); end
            if (c == 3) begin
                n_vec++; if ({rsp_valid, busy, req_ready} !== {1'b0, 1'b0, 4'b0001}) begin n_err++; $display("FAIL flush after_sclr got v%b busy%b ready %b want v0 busy0 ready 0001", rsp_valid, busy, req_ready); end
            end
            model_commit();
            @(posedge clk); #1;
        end
        req_valid = '0;
    endtask

    initial begin
        sclr      = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        last_acc  = -1;
        for (int s = 1; s <= L; s++) begin
            m_v[s] = 1'b0; m_id[s] = 0; m_y[s] = '0;
        end
        @(posedge clk); #1;
        test_reset();
        test_single("basic", 27'd3, 27'd5, 54'd15, 54'd15);
        test_single("minus1x2", 27'h7FFFFFF, 27'd2, 54'h3FFFFFFFFFFFFE, 54'h0000000FFFFFFE);
        test_stream("all_valid", 16, 1000, 1'b0);
        test_stream("stall", 20, 4, 1'b0);
        test_stream("rnd_ready", 40, 1000, 1'b1);
        test_rr_order();
        test_flush();
        test_random(120);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mistral_mul_share.md
Name: mistral_mul_share

Overview:
Shares one MISTRAL_MUL27X27 hard multiplier between NREQ requesters.
- Each requester has a valid/ready operand port.
- A round-robin arbiter issues at most one product per cycle into a LATENCY-stage pipeline.
- Results leave on a single tagged response port with backpressure.
- Used wherever several low-rate datapaths would otherwise each burn a DSP block.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- LATENCY, 2: cycles from accept edge to RSP_VALID, 1..4.
- SIGNED, 1: 1 means signed 27x27 (A_SIGNED=B_SIGNED=1); 0 means unsigned. Fixed per instance.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- SCLR  in  1  synchronous active-high reset.
- REQ_VALID  in  NREQ  operand valid per requester.
- REQ_READY  out  NREQ  accept per requester; one-hot or zero.
- REQ_A  in  NREQ*27  operand A; requester i uses bits [27*i+26:27*i].
- REQ_B  in  NREQ*27  operand B; same packing as REQ_A.
- RSP_VALID  out  1  result valid.
- RSP_READY  in  1  consumer accepts result.
- RSP_ID  out  $clog2(NREQ)  index of the requester that issued the result.
- RSP_Y  out  54  product.
- BUSY  out  1  any pipeline stage holds a valid entry.

Behaviour:
- Interface: one clock (CLK); reset SCLR is synchronous and active-high.
- Reset: while SCLR=1 at an edge:
  - all stage valids clear;
  - RR pointer resets to 0;
  - RSP_VALID=0 and BUSY=0 from the next cycle.
  - REQ_READY is forced 0 combinationally during any cycle with SCLR=1.
- Reset mid-operation: in-flight products are discarded, never delivered.
- Pipeline: stages s1..sLATENCY, each holding valid, ID and data.
  - s1 holds A, B and ID.
  - The product is formed combinationally from s1 by MISTRAL_MUL27X27.
  - s2..sLATENCY carry the 54-bit product.
  - When LATENCY=1, RSP_Y is the combinational product of s1.
  - RSP_* outputs are driven from sLATENCY.
- Advance: adv = !sLATENCY.valid | RSP_READY.
  - When adv=1, all stages shift by one.
  - When adv=0, the whole pipe freezes, bubbles included; no bubble collapsing.
  - RSP_VALID, RSP_ID and RSP_Y hold stable while RSP_VALID=1 and RSP_READY=0.
- Accept: REQ_READY[i] = grant[i] & adv & !SCLR.
  - A transfer occurs on an edge where REQ_VALID[i] & REQ_READY[i] = 1.
  - The transfer loads s1 with valid=1.
  - On an edge with adv=1 and no transfer, s1.valid loads 0.
- Latency: an accept at edge k, with no stalls, gives RSP_VALID=1 in the cycle after edge k+LATENCY-1. Peak throughput is one result per cycle.
- Arbitration: grant goes to the first i with REQ_VALID[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - On a transfer, ptr <= (granted+1) mod NREQ.
  - With no transfer, ptr is held.
  - Starvation bound: a continuously valid requester waits at most NREQ-1 transfers.
- Handshake rules:
  - grant may depend on REQ_VALID.
  - Requesters must not make REQ_VALID depend on REQ_READY.
  - Operands must stay stable while valid and not accepted.
  - A requester that deasserts REQ_VALID before acceptance loses its slot, with no error.
- Ordering: results appear in accept order; RSP_ID identifies the issuing requester.
- Arithmetic:
  - SIGNED=1: two's-complement 27x27 into 54 bits, full precision, no overflow possible.
  - SIGNED=0: unsigned, zero-extended.
- BUSY = OR of all stage valids.

Decomposition:
- Package mistral_mul_pkg:
  - MUL_W=27, PROD_W=54;
  - function id_width(n) = max(1, $clog2(n));
  - packed stage struct {valid, id, a, b}.
- One natural sub-module: mistral_rr_arbiter. It is parameterised by N and takes:
  - inputs req[N], ptr, advance_en;
  - outputs one-hot grant[N] and registered ptr.
- The pipeline and multiplier instance stay in mistral_mul_share.

Test Plan:
1. NREQ=4, LATENCY=2, SIGNED=1; requester 0 sends A=3, B=5 with RSP_READY=1 -> accepted at edge k; RSP_VALID=1 after edge k+1 with RSP_Y=15, RSP_ID=0; BUSY drops after the response.
2. SIGNED=1, A=27'h7FFFFFF (-1), B=2 -> RSP_Y=54'h3FFFFFFFFFFFFE. With SIGNED=0, same operands -> RSP_Y=54'h0000000FFFFFFE.
3. All four REQ_VALID held high, RSP_READY=1 -> one accept per cycle, RSP_ID sequence 0,1,2,3,0,1,..., products matching operands.
4. Pipe full, RSP_READY=0 for 3 cycles -> REQ_READY all 0; RSP_Y/RSP_ID unchanged; on release, no result lost or duplicated and order preserved.
5. After a grant to requester 2, only requesters 1 and 3 valid -> requester 3 granted next, then 1.
6. Two requests in flight, SCLR pulsed one cycle -> RSP_VALID=0 and BUSY=0 next cycle; no RSP for the flushed IDs; ptr=0 so requester 0 wins the next contention.
